// File: rtl/lane_gather_serializer_pkg.sv
// Shared definitions for the lane gather serializer: lane count, index
// type, mask type and the controller state encoding.
package lane_gather_serializer_pkg;

  // Number of vector lanes gathered per load; index codes 24..31 are unused.
  localparam int LANES = 24;

  // Width of the lane index; 5 bits cover lanes 0..23.
  localparam int IDX_W = 5;

  // Default element width in bits, used by the interface and the top.
  localparam int WIDTH_DEFAULT = 8;

  typedef logic [IDX_W-1:0] lane_idx_t;
  typedef logic [LANES-1:0] lane_mask_t;

  // Highest legal lane index; the final element of an unmasked vector.
  localparam lane_idx_t LAST_IDX = lane_idx_t'(LANES - 1);

  // IDLE: ready to capture a vector. SCAN: streaming the captured lanes.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } gather_state_t;

endpackage

// File: rtl/lane_gather_serializer_if.sv
// Load and output streams of the lane gather serializer.
// slave  : the serializer's own view (captures the load, drives the stream).
// master : the surrounding logic (presents vectors, consumes elements).
interface lane_gather_serializer_if #(
  parameter int WIDTH = lane_gather_serializer_pkg::WIDTH_DEFAULT
);
  import lane_gather_serializer_pkg::*;

  // Vector capture side.
  logic                   load_valid;
  logic                   load_ready;
  logic [LANES*WIDTH-1:0] lane_data;
  lane_mask_t             lane_mask;

  // Scalar element stream.
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  lane_idx_t              out_idx;
  logic                   out_last;

  modport master (
    output load_valid,
    output lane_data,
    output lane_mask,
    output out_ready,
    input  load_ready,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last
  );

  modport slave (
    input  load_valid,
    input  lane_data,
    input  lane_mask,
    input  out_ready,
    output load_ready,
    output out_valid,
    output out_data,
    output out_idx,
    output out_last
  );

endinterface

// File: rtl/lane_gather_serializer_lane_next_finder.sv
// Priority search over the lane mask: returns the lowest enabled lane whose
// index is >= 'from', and whether any such lane exists. With from = 0 it
// yields the first lane of a fresh vector; with from = idx+1 it yields the
// successor of the current lane (from may be 24, which finds nothing).
// Only present when LANE_SKIP_EN is defined; the unmasked build walks the
// lanes with a plain counter and needs no search.
`ifdef LANE_SKIP_EN
module lane_next_finder
  import lane_gather_serializer_pkg::*;
(
  input  lane_mask_t mask,
  input  lane_idx_t  from,
  output lane_idx_t  idx,
  output logic       found
);

  // Scan from the top down so the lowest qualifying lane is the last write.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional write, otherwise the tool infers a latch to hold it.
    idx   = '0;
    found = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (lane_idx_t'(i) >= from)) begin
        idx   = lane_idx_t'(i);
        found = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/lane_gather_serializer.sv
// Lane gather serializer: captures a 24-lane vector in one cycle and then
// emits the lanes one per cycle on a valid/ready stream, lowest lane first.
//
// Build option LANE_SKIP_EN:
//   defined   - lane_mask selects the lanes to emit; disabled lanes cost no
//               bubbles and an all-zero mask emits nothing.
//   undefined - lane_mask is ignored; every load emits lanes 0..23 in order.
module lane_gather_serializer
  import lane_gather_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  lane_gather_serializer_if.slave  bus
);

  gather_state_t                 state_q;
  gather_state_t                 state_d;
  lane_idx_t                     idx_q;
  lane_idx_t                     idx_d;
  logic [LANES-1:0][WIDTH-1:0]   data_q;
  logic                          capture;

  // Lane selection helpers, supplied by the build-specific block below.
  lane_idx_t                     start_idx;  // first lane of the incoming vector
  logic                          start_go;   // incoming vector has lanes to emit
  lane_idx_t                     step_idx;   // lane that follows idx_q
  logic                          last;       // idx_q is the final lane to emit

`ifdef LANE_SKIP_EN
  lane_mask_t                    mask_q;
  lane_mask_t                    find_mask;
  lane_idx_t                     find_from;
  lane_idx_t                     find_idx;
  logic                          find_hit;

  // One search serves both roles: in IDLE it looks at the incoming mask from
  // lane 0, in SCAN it looks at the captured mask strictly above idx_q.
  assign find_mask = (state_q == IDLE) ? bus.lane_mask : mask_q;
  assign find_from = (state_q == IDLE) ? lane_idx_t'(0) : idx_q + lane_idx_t'(1);

  lane_next_finder u_next_finder (
    .mask  (find_mask),
    .from  (find_from),
    .idx   (find_idx),
    .found (find_hit)
  );

  assign start_idx = find_idx;
  assign start_go  = find_hit;
  assign step_idx  = find_idx;
  assign last      = ~find_hit;

  // Capture the lane mask alongside the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (capture) begin
      mask_q <= bus.lane_mask;
    end
  end
`else
  // Every lane is emitted, so the index is a plain 0..23 counter.
  logic unused_lane_mask;

  assign unused_lane_mask = ^bus.lane_mask;
  assign start_idx        = '0;
  assign start_go         = 1'b1;
  assign step_idx         = idx_q + lane_idx_t'(1);
  assign last             = (idx_q == LAST_IDX);
`endif

  // State and lane index registers.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and index: capture in IDLE, advance or finish in SCAN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          capture = 1'b1;
          idx_d   = start_idx;
          if (start_go) begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // load_valid is deliberately ignored until the vector drains.
        if (bus.out_ready) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = step_idx;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Vector capture register.
  always_ff @(posedge clk) begin
    // NOTE: the lane storage is reset as well, so a reset leaves no stale
    // vector behind; it is a plain register bank, not a RAM macro.
    if (!rst_n) begin
      data_q <= '0;
    end else if (capture) begin
      data_q <= bus.lane_data;
    end
  end

  // Stream outputs: 24:1 select of the current lane, forced to 0 when idle.
  assign bus.load_ready = (state_q == IDLE);
  assign bus.out_valid  = (state_q == SCAN);
  assign bus.out_data   = (state_q == SCAN) ? data_q[idx_q] : '0;
  assign bus.out_idx    = idx_q;
  assign bus.out_last   = (state_q == SCAN) && last;

endmodule

// File: tb/tb_lane_gather_serializer.sv
// Self-checking bench for lane_gather_serializer. A reference model turns
// each loaded vector into the ordered list of (lane, element) pairs the
// stream must deliver; the bench drives random back-pressure and random
// load traffic and compares every presented element against that list.
module tb_lane_gather_serializer;
  import lane_gather_serializer_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  typedef logic [LANES*W-1:0] vec_t;
  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lane_gather_serializer_if #(.WIDTH(W)) bus ();

  lane_gather_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // Expected element list: enabled lanes in ascending order.
  task automatic build_expect(input vec_t data, input lane_mask_t mask);
    lane_mask_t eff;
    eff = mask;
`ifndef LANE_SKIP_EN
    eff = '1;
`endif
    q.delete();
    for (int i = 0; i < LANES; i++) begin
      if (eff[i]) q.push_back('{idx: i, data: data[i*W +: W]});
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".load_ready"}, 32'(bus.load_ready), 32'd1);
    check({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
    check({tag, ".out_data"},   32'(bus.out_data),   32'd0);
    check({tag, ".out_last"},   32'(bus.out_last),   32'd0);
  endtask

  // Compare the presented element against the head of the expected list.
  task automatic check_head();
    check("scan.out_valid",  32'(bus.out_valid),  32'd1);
    check("scan.load_ready", 32'(bus.load_ready), 32'd0);
    check("scan.out_idx",    32'(bus.out_idx),    32'(q[0].idx));
    check("scan.out_data",   32'(bus.out_data),   32'(q[0].data));
    check("scan.out_last",   32'(bus.out_last),   32'(q.size() == 1));
  endtask

  // Present one vector at a negedge; the DUT captures it at the next posedge.
  task automatic load_vector(input vec_t data, input lane_mask_t mask);
    @(negedge clk);
    check("load.load_ready", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.lane_data  = data;
    bus.lane_mask  = mask;
    build_expect(data, mask);
    @(negedge clk);
  endtask

  // mode 0: ready always high; 1: random ready; 2: stall 3 cycles at lane 2.
  task automatic run_vector(input vec_t data, input lane_mask_t mask,
                            input int mode, input bit hold_load);
    int cycles;
    int stall;
    cycles = 0;
    stall  = 0;
    load_vector(data, mask);
    while (q.size() != 0 && cycles < 200) begin
      check_head();
      if (hold_load) begin
        bus.load_valid = 1'b1;
        bus.lane_data  = rand_vec();
        bus.lane_mask  = lane_mask_t'($urandom);
      end else begin
        bus.load_valid = 1'b0;
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (q[0].idx == 2 && stall < 3) begin
            bus.out_ready = 1'b0;
            stall++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
      endcase
      if (bus.out_ready) void'(q.pop_front());
      cycles++;
      @(negedge clk);
    end
    check("drain.remaining", 32'(q.size()), 32'd0);
    bus.load_valid = 1'b0;
    check_idle("done");
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_idle("done2");
  endtask

  // Load a full vector, stream up to lane 5, then reset while it is shown.
  task automatic run_reset_abort();
    int cycles;
    cycles = 0;
    load_vector(rand_vec(), '1);
    bus.load_valid = 1'b0;
    while (q.size() != 0 && q[0].idx != 5 && cycles < 50) begin
      check_head();
      bus.out_ready = 1'b1;
      void'(q.pop_front());
      cycles++;
      @(negedge clk);
    end
    check_head();
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_idle("abort");
    check("abort.out_idx", 32'(bus.out_idx), 32'd0);
    rst_n = 1'b1;
    q.delete();
  endtask

  initial begin
    vec_t ramp;

    rst_n          = 1'b0;
    bus.load_valid = 1'b0;
    bus.lane_data  = '0;
    bus.lane_mask  = '0;
    bus.out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset");
    check("reset.out_idx", 32'(bus.out_idx), 32'd0);

    // Full vector with a recognisable ramp, continuous ready.
    for (int i = 0; i < LANES; i++) ramp[i*W +: W] = W'(8'h10 + i);
    run_vector(ramp, '1, 0, 1'b0);

    // Sparse mask touching both ends of the lane range.
    run_vector(rand_vec(), 24'h800005, 0, 1'b0);

    // Back-pressure while lane 2 is presented.
    run_vector(rand_vec(), 24'h000a14, 2, 1'b0);

    // Empty mask.
    run_vector(rand_vec(), '0, 0, 1'b0);

    // Reset mid-vector, then a fresh load from its lowest enabled lane.
    run_reset_abort();
    run_vector(rand_vec(), 24'h000060, 0, 1'b0);

    // load_valid held high with changing data during the scan.
    run_vector(rand_vec(), lane_mask_t'($urandom), 1, 1'b1);

    // Random traffic.
    for (int n = 0; n < 20; n++) begin
      lane_mask_t m;
      m = ($urandom_range(0, 1) != 0) ? lane_mask_t'($urandom & $urandom)
                                      : lane_mask_t'($urandom);
      run_vector(rand_vec(), m, 1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
